// File: rtl/mul_ctrl_pkg.sv
// Shared constants for the M-extension multiply controller: funct3 codes and FSM state encodings.
package mul_ctrl_pkg;

  localparam logic [2:0] MUL_OP_MUL    = 3'b000;
  localparam logic [2:0] MUL_OP_MULH   = 3'b001;
  localparam logic [2:0] MUL_OP_MULHSU = 3'b010;
  localparam logic [2:0] MUL_OP_MULHU  = 3'b011;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic op_is_high(input logic [2:0] op);
    return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU) || (op == MUL_OP_MULHU);
  endfunction

endpackage

// File: rtl/mul_res_fmt.sv
// Combinational product formatter: selects high/low half or sign-extends the 32-bit W-form result.
module mul_res_fmt
  import mul_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]        op,
  input  logic              word,
  input  logic [2*XLEN-1:0] prod,
  output logic [XLEN-1:0]   res
);

  always_comb begin
    res = prod[XLEN-1:0];
    if (op_is_high(op))
      res = prod[2*XLEN-1:XLEN];
    else if (word)
      res = {{(XLEN-32){prod[31]}}, prod[31:0]};
  end

endmodule

// File: rtl/mul_ctrl.sv
// Sequencer for the iterative radix-4 Booth multiplier: latches one op, holds mul_valid until
// mul_ready, formats the product. Optional last-result cache under `MUL_RESULT_CACHE_EN`.
module mul_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic              in_word,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic [XLEN-1:0]   in_rs2,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic              busy,
  output logic              mul_valid,
  output logic              mul_rs1_sign,
  output logic              mul_rs2_sign,
  output logic [XLEN-1:0]   mul_rs1_data,
  output logic [XLEN-1:0]   mul_rs2_data,
  input  logic              mul_ready,
  input  logic [2*XLEN-1:0] mul_result
);

  logic [1:0]        state;
  logic [XLEN-1:0]   rs1_q, rs2_q, out_q;
  logic              s1_q, s2_q, word_q;
  logic [2:0]        op_q;
  logic              accept, in_s1, in_s2, hit;
  logic [2:0]        fmt_op;
  logic              fmt_word;
  logic [2*XLEN-1:0] fmt_prod;
  logic [XLEN-1:0]   fmt_res;

  assign accept = in_valid & in_ready & ~flush;
  // Low product bits do not depend on signedness, so MUL/MULW/MULHU all run unsigned.
  assign in_s1  = ((in_op == MUL_OP_MULH) || (in_op == MUL_OP_MULHSU)) & in_rs1[XLEN-1];
  assign in_s2  = (in_op == MUL_OP_MULH) & in_rs2[XLEN-1];

`ifdef MUL_RESULT_CACHE_EN
  logic              c_vld, c_s1, c_s2;
  logic [XLEN-1:0]   c_rs1, c_rs2;
  logic [2*XLEN-1:0] c_prod;

  assign hit      = c_vld & (c_s1 == in_s1) & (c_s2 == in_s2) & (c_rs1 == in_rs1) & (c_rs2 == in_rs2);
  assign fmt_prod = (state == ST_IDLE) ? c_prod : mul_result;

  // Any flush invalidates the entry; a killed op must not seed a later hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_vld  <= 1'b0;
      c_s1   <= 1'b0;
      c_s2   <= 1'b0;
      c_rs1  <= '0;
      c_rs2  <= '0;
      c_prod <= '0;
    end else if (flush) begin
      c_vld <= 1'b0;
    end else if (state == ST_BUSY && mul_ready) begin
      c_vld  <= 1'b1;
      c_s1   <= s1_q;
      c_s2   <= s2_q;
      c_rs1  <= rs1_q;
      c_rs2  <= rs2_q;
      c_prod <= mul_result;
    end
  end
`else
  assign hit      = 1'b0;
  assign fmt_prod = mul_result;
`endif

  // IDLE formats a cache hit from the incoming op; BUSY formats the live product.
  assign fmt_op   = (state == ST_IDLE) ? in_op : op_q;
  assign fmt_word = (state == ST_IDLE) ? in_word : word_q;

  mul_res_fmt #(.XLEN(XLEN)) u_fmt (
    .op   (fmt_op),
    .word (fmt_word),
    .prod (fmt_prod),
    .res  (fmt_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      rs1_q  <= '0;
      rs2_q  <= '0;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      op_q   <= 3'b000;
      word_q <= 1'b0;
      out_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          rs1_q  <= in_rs1;
          rs2_q  <= in_rs2;
          s1_q   <= in_s1;
          s2_q   <= in_s2;
          op_q   <= in_op;
          word_q <= in_word;
          if (hit) begin
            out_q <= fmt_res;
            state <= ST_DONE;
          end else begin
            state <= ST_BUSY;
          end
        end
        // mul_valid stays up through the mul_ready cycle so the multiplier clears its counter.
        ST_BUSY: begin
          if (mul_ready && flush) begin
            state <= ST_IDLE;
          end else if (mul_ready) begin
            out_q <= fmt_res;
            state <= ST_DONE;
          end else if (flush) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: if (mul_ready) state <= ST_IDLE;
        ST_DONE:  if (flush || out_ready) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready     = (state == ST_IDLE);
  assign out_valid    = (state == ST_DONE);
  assign busy         = (state != ST_IDLE);
  assign mul_valid    = (state == ST_BUSY) || (state == ST_DRAIN);
  assign out_data     = out_q;
  assign mul_rs1_sign = s1_q;
  assign mul_rs2_sign = s2_q;
  assign mul_rs1_data = rs1_q;
  assign mul_rs2_data = rs2_q;

endmodule
